exonbus_seq: RTL

- Control-side initiator for the shared 8-bit tristate transfer bus. Drives the bus enables eni/ena/enb/enc and the register loads lda/ldb/ldc.
- Accepts register-to-register move commands over a valid/ready interface and buffers them in a small FIFO.
- Sequences each move as drive, settle, load, then break-before-make. At most one driver is ever on the bus, and a register is loaded only while exactly one driver is on.

---
 rtl/exonbus_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/exonbus_seq.sv
// exonbus_seq: transfer-bus initiator; queues src->dst move commands and sequences bus enables/loads.
// Ports: clk, rst_n (async, active-low); cmd_valid/cmd_ready/cmd_src/cmd_dst command push;
//        eni/ena/enb/enc bus drive enables; lda/ldb/ldc load strobes; busy, done, err, xfer_cnt status.
module exonbus_seq #(
  parameter int DEPTH      = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_src,
  input  logic [2:0] cmd_dst,
  output logic       eni,
  output logic       ena,
  output logic       enb,
  output logic       enc,
  output logic       lda,
  output logic       ldb,
  output logic       ldc,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] xfer_cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, DRIVE, LOAD, GAP} state_t;
  state_t state_q, state_d;
  logic [4:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic [3:0] settle_q, settle_d;
  logic [1:0] src_q, src_d;
  logic [2:0] dst_q, dst_d;
  logic [3:0] en_q, en_d;
  logic [2:0] ld_q, ld_d;
  logic done_q, done_d, err_q, err_d;
  logic [7:0] xfer_q, xfer_d;
  logic push, pop;
  logic [1:0] head_src;
  logic [2:0] head_dst;
  assign cmd_ready = cnt_q != FULL;
  assign push = cmd_valid && cmd_ready;
  assign pop = state_q == IDLE && cnt_q != '0;
  assign {head_src, head_dst} = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {cmd_src, cmd_dst};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    src_d    = src_q;
    dst_d    = dst_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          if (head_dst == 3'b000) err_d = 1'b1;
          else begin
            src_d    = head_src;
            dst_d    = head_dst;
            settle_d = 4'(SETTLE_CYC);
            state_d  = (SETTLE_CYC == 0) ? LOAD : DRIVE;
          end
        end
      end
      DRIVE: begin
        settle_d = settle_q - 4'd1;
        if (settle_q <= 4'd1) state_d = LOAD;
      end
      LOAD:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  assign en_d   = (state_d == DRIVE || state_d == LOAD) ? (4'b0001 << src_d) : 4'b0000;
  assign ld_d   = (state_d == LOAD) ? dst_d : 3'b000;
  assign done_d = state_d == GAP;
  assign xfer_d = xfer_q + 8'(done_d);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      en_q     <= '0;
      ld_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      xfer_q   <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      en_q     <= en_d;
      ld_q     <= ld_d;
      done_q   <= done_d;
      err_q    <= err_d;
      xfer_q   <= xfer_d;
    end
  end
  assign {enc, enb, ena, eni} = en_q;
  assign {ldc, ldb, lda} = ld_q;
  assign done = done_q;
  assign err = err_q;
  assign xfer_cnt = xfer_q;
  assign busy = state_q != IDLE || cnt_q != '0;
endmodule
